// File: rtl/ntr_if.sv
// ============================================================================
// Module      : ntr_if
// Description : Command bus bundle between the cartridge-side bus driver and
//               the NTR command capture block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ntr_if #(
    parameter int CMD_BYTES = 8
);
    logic                     ntr_cs1;
    logic [7:0]               ntr_data;
    logic [CMD_BYTES*8-1:0]   command;
    logic                     ready;
    logic [2:0]               count;

    modport master (
        output ntr_cs1,
        output ntr_data,
        input  command,
        input  ready,
        input  count
    );

    modport slave (
        input  ntr_cs1,
        input  ntr_data,
        output command,
        output ready,
        output count
    );
endinterface

`default_nettype wire

// File: rtl/ntr.sv
// ============================================================================
// Module      : ntr
// Description : Captures an 8-byte command frame from the NTR bus while chip
//               select is low; all outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ntr #(
    parameter int CMD_BYTES = 8
) (
    input  wire        ntr_clk,
    input  wire        rst_n,
    ntr_if.slave       bus
);

    localparam int           CMD_W    = CMD_BYTES * 8;
    localparam logic [2:0]   LAST_IDX = 3'(CMD_BYTES - 1);

    localparam logic [1:0]   ST_IDLE  = 2'd0;
    localparam logic [1:0]   ST_CMD   = 2'd1;
    localparam logic [1:0]   ST_DATA  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;

    logic [CMD_W-1:0] command_q;
    logic [CMD_W-1:0] command_next;
    logic [2:0]       count_q;
    logic [2:0]       count_next;
    logic             ready_q;
    logic             ready_next;

    // State register
    always_ff @(posedge ntr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a high chip select always returns to IDLE
    always_comb begin
        state_next = state;
        if (bus.ntr_cs1) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state_next = ST_CMD;
                ST_CMD:  if (count_q == LAST_IDX) state_next = ST_DATA;
                ST_DATA: state_next = ST_DATA;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Output next-values; registered below so no input reaches an output combinationally
    always_comb begin
        command_next = command_q;
        count_next   = count_q;
        ready_next   = ready_q;
        if (bus.ntr_cs1) begin
            count_next = 3'd0;
            ready_next = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    command_next = {command_q[CMD_W-9:0], bus.ntr_data};
                    count_next   = 3'd1;
                    ready_next   = 1'b0;
                end
                ST_CMD: begin
                    command_next = {command_q[CMD_W-9:0], bus.ntr_data};
                    if (count_q == LAST_IDX) begin
                        count_next = 3'd0;
                        ready_next = 1'b1;
                    end else begin
                        count_next = count_q + 3'd1;
                        ready_next = 1'b0;
                    end
                end
                ST_DATA: begin
                    count_next = 3'd0;
                    ready_next = 1'b1;
                end
                default: begin
                    count_next = 3'd0;
                    ready_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge ntr_clk or negedge rst_n) begin
        if (!rst_n) begin
            command_q <= '0;
            count_q   <= 3'd0;
            ready_q   <= 1'b0;
        end else begin
            command_q <= command_next;
            count_q   <= count_next;
            ready_q   <= ready_next;
        end
    end

    assign bus.command = command_q;
    assign bus.count   = count_q;
    assign bus.ready   = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_ntr.sv
// ============================================================================
// Module      : tb_ntr
// Description : Scoreboard testbench for the NTR command capture block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ntr;

    typedef struct packed {
        logic [63:0] cmd;
        logic [2:0]  cnt;
        logic        rdy;
    } exp_t;

    logic ntr_clk;
    logic rst_n;

    ntr_if #(.CMD_BYTES(8)) bus ();

    ntr #(.CMD_BYTES(8)) u_dut (
        .ntr_clk (ntr_clk),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    initial ntr_clk = 1'b0;
    always #5 ntr_clk = ~ntr_clk;

    int   n_checks;
    int   n_pass;
    exp_t exp_q[$];

    // Reference model state: bytes taken in the current frame (saturates at 8)
    logic [63:0] m_cmd;
    int          m_bytes;
    int          ready_pulses;
    logic        prev_ready;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_cmd   = 64'h0;
        m_bytes = 0;
    endtask

    // Drive one bus cycle, predict its result, then compare after the edge
    task automatic step(input logic cs1, input logic [7:0] data);
        exp_t e;
        exp_t got;
        @(negedge ntr_clk);
        bus.ntr_cs1  = cs1;
        bus.ntr_data = data;
        if (cs1) begin
            m_bytes = 0;
        end else if (m_bytes < 8) begin
            m_cmd   = {m_cmd[55:0], data};
            m_bytes = m_bytes + 1;
        end
        e.cmd = m_cmd;
        e.cnt = 3'(m_bytes % 8);
        e.rdy = (m_bytes == 8);
        exp_q.push_back(e);
        @(posedge ntr_clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 64'd0, 64'd1);
        end else begin
            got = exp_q.pop_front();
            check("command", bus.command, got.cmd);
            check("count", {61'd0, bus.count}, {61'd0, got.cnt});
            check("ready", {63'd0, bus.ready}, {63'd0, got.rdy});
        end
        if (bus.ready && !prev_ready) ready_pulses++;
        prev_ready = bus.ready;
    endtask

    task automatic send_frame(input logic [63:0] v);
        for (int i = 7; i >= 0; i--) begin
            step(1'b0, v[i*8 +: 8]);
        end
    endtask

    initial begin
        logic [63:0] f1;
        logic [63:0] f2;
        n_checks     = 0;
        n_pass       = 0;
        ready_pulses = 0;
        prev_ready   = 1'b0;
        rst_n        = 1'b0;
        bus.ntr_cs1  = 1'b1;
        bus.ntr_data = 8'h00;
        model_reset();

        #3;
        check("reset_command", bus.command, 64'h0);
        check("reset_count", {61'd0, bus.count}, 64'd0);
        check("reset_ready", {63'd0, bus.ready}, 64'd0);
        @(negedge ntr_clk);
        rst_n = 1'b1;

        // Basic frame, first capture directly after reset release
        send_frame(64'h01000000000000FF);
        check("frame1_value", bus.command, 64'h01000000000000FF);
        check("frame1_ready", {63'd0, bus.ready}, 64'd1);

        // Extra bytes ignored while selected, then deselect
        for (int i = 0; i < 4; i++) step(1'b0, 8'hAA);
        check("extra_hold", bus.command, 64'h01000000000000FF);
        step(1'b1, 8'h5A);
        check("deselect_ready", {63'd0, bus.ready}, 64'd0);

        // Data changes while deselected must not matter
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom_range(0, 255)));

        // Partial frame aborted
        ready_pulses = 0;
        step(1'b0, 8'h11);
        step(1'b0, 8'h22);
        step(1'b0, 8'h33);
        step(1'b1, 8'h00);
        check("partial_low24", {40'd0, bus.command[23:0]}, 64'h112233);
        check("partial_no_ready", 64'(ready_pulses), 64'd0);

        // Asynchronous reset mid-frame, between clock edges
        for (int i = 0; i < 5; i++) step(1'b0, 8'(8'hC0 + i));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_command", bus.command, 64'h0);
        check("async_rst_count", {61'd0, bus.count}, 64'd0);
        check("async_rst_ready", {63'd0, bus.ready}, 64'd0);
        #1;
        rst_n = 1'b1;
        bus.ntr_cs1 = 1'b1;
        prev_ready  = 1'b0;
        step(1'b1, 8'h00);
        send_frame(64'hDEADBEEFCAFEF00D);
        check("post_rst_frame", bus.command, 64'hDEADBEEFCAFEF00D);
        step(1'b1, 8'h00);

        // Back-to-back frames with a single deselect edge between them
        ready_pulses = 0;
        f1 = 64'h0102030405060708;
        f2 = 64'hF0E0D0C0B0A09080;
        send_frame(f1);
        check("b2b_frame1", bus.command, f1);
        step(1'b1, 8'hFF);
        send_frame(f2);
        check("b2b_frame2", bus.command, f2);
        step(1'b1, 8'h00);
        check("b2b_pulses", 64'(ready_pulses), 64'd2);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule

`default_nettype wire
